// File: rtl/wb_pkg.sv
// Shared encodings for the write-back stage: result-source selects and FSM states.
package wb_pkg;

    typedef enum logic [1:0] {
        SRC_ALU    = 2'd0,
        SRC_MEM    = 2'd1,
        SRC_INPORT = 2'd2,
        SRC_IMM    = 2'd3
    } resultSrc_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRIMARY = 2'd1,
        SECOND  = 2'd2
    } wbState_t;

endpackage

// File: rtl/wb_result_mux.sv
// Combinational 4:1 selector choosing the retiring instruction's result source.
module wb_result_mux
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic [1:0]            sel,
    input  logic [DATA_WIDTH-1:0] aluData,
    input  logic [DATA_WIDTH-1:0] memData,
    input  logic [DATA_WIDTH-1:0] inPortData,
    input  logic [DATA_WIDTH-1:0] immData,
    output logic [DATA_WIDTH-1:0] result
);

    // Source selection by resultSel encoding
    always_comb begin
        result = aluData;
        case (sel)
            SRC_ALU:    result = aluData;
            SRC_MEM:    result = memData;
            SRC_INPORT: result = inPortData;
            SRC_IMM:    result = immData;
            default:    result = aluData;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Write-back stage: registered primary/second register writes, private-register path,
// forwarding mirror of the register-file port, and a retired-instruction counter.
module writeback_stage
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      inValid,
    output logic                      inReady,
    input  logic                      regWrite,
    input  logic [1:0]                resultSel,
    input  logic                      dstOrPrivate,
    input  logic [REG_ADDR_WIDTH-1:0] dstAddress,
    input  logic [DATA_WIDTH-1:0]     aluData,
    input  logic [DATA_WIDTH-1:0]     memData,
    input  logic [DATA_WIDTH-1:0]     inPortData,
    input  logic [DATA_WIDTH-1:0]     immData,
    input  logic                      dualWrite,
    input  logic [REG_ADDR_WIDTH-1:0] secondAddress,
    input  logic [DATA_WIDTH-1:0]     secondData,
    output logic                      rfWriteEn,
    output logic [REG_ADDR_WIDTH-1:0] rfWriteAddr,
    output logic [DATA_WIDTH-1:0]     rfWriteData,
    output logic                      privateWriteEn,
    output logic [DATA_WIDTH-1:0]     privateWriteData,
    output logic                      fwdValid,
    output logic [REG_ADDR_WIDTH-1:0] fwdAddr,
    output logic [DATA_WIDTH-1:0]     fwdData,
    output logic [COUNT_WIDTH-1:0]    retiredCount
);

    wbState_t                  stateR;
    wbState_t                  nextStateS;
    logic                      acceptS;
    logic                      issueSecondS;
    logic [DATA_WIDTH-1:0]     muxResultS;
    logic [REG_ADDR_WIDTH-1:0] secondAddrR;
    logic [DATA_WIDTH-1:0]     secondDataR;

    wb_result_mux #(.DATA_WIDTH(DATA_WIDTH)) uMux (
        .sel        (resultSel),
        .aluData    (aluData),
        .memData    (memData),
        .inPortData (inPortData),
        .immData    (immData),
        .result     (muxResultS)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            stateR <= IDLE;
        end else begin
            stateR <= nextStateS;
        end
    end

    // FSM next-state logic; dual writes only count when the instruction writes at all
    always_comb begin
        nextStateS = stateR;
        if (acceptS) begin
            nextStateS = (regWrite && dualWrite) ? SECOND : PRIMARY;
        end else if (stateR == SECOND) begin
            nextStateS = PRIMARY;
        end else begin
            nextStateS = IDLE;
        end
    end

    // FSM outputs: handshake and second-write issue; inReady never depends on inValid
    always_comb begin
        inReady      = !rst && (stateR != SECOND);
        acceptS      = inValid && inReady;
        issueSecondS = (stateR == SECOND);
    end

    // Hold the second destination of a dual write until its issue cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            secondAddrR <= {REG_ADDR_WIDTH{1'b0}};
            secondDataR <= {DATA_WIDTH{1'b0}};
        end else if (acceptS && regWrite && dualWrite) begin
            secondAddrR <= secondAddress;
            secondDataR <= secondData;
        end
    end

    // Registered write ports; data outputs hold when their strobe is not raised
    always_ff @(posedge clk) begin
        if (rst) begin
            rfWriteEn        <= 1'b0;
            rfWriteAddr      <= {REG_ADDR_WIDTH{1'b0}};
            rfWriteData      <= {DATA_WIDTH{1'b0}};
            privateWriteEn   <= 1'b0;
            privateWriteData <= {DATA_WIDTH{1'b0}};
        end else if (acceptS) begin
            rfWriteEn      <= regWrite && !dstOrPrivate;
            privateWriteEn <= regWrite && dstOrPrivate;
            if (regWrite && !dstOrPrivate) begin
                rfWriteAddr <= dstAddress;
                rfWriteData <= muxResultS;
            end
            if (regWrite && dstOrPrivate) begin
                privateWriteData <= muxResultS;
            end
        end else if (issueSecondS) begin
            rfWriteEn      <= 1'b1;
            rfWriteAddr    <= secondAddrR;
            rfWriteData    <= secondDataR;
            privateWriteEn <= 1'b0;
        end else begin
            rfWriteEn      <= 1'b0;
            privateWriteEn <= 1'b0;
        end
    end

    // Retired-instruction counter, one per capture, wrapping naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            retiredCount <= {COUNT_WIDTH{1'b0}};
        end else if (acceptS) begin
            retiredCount <= retiredCount + COUNT_WIDTH'(1);
        end
    end

    assign fwdValid = rfWriteEn;
    assign fwdAddr  = rfWriteAddr;
    assign fwdData  = rfWriteData;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model.
module tb_writeback_stage;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          inValid;
    logic          inReady;
    logic          regWrite;
    logic [1:0]    resultSel;
    logic          dstOrPrivate;
    logic [AW-1:0] dstAddress;
    logic [DW-1:0] aluData, memData, inPortData, immData;
    logic          dualWrite;
    logic [AW-1:0] secondAddress;
    logic [DW-1:0] secondData;
    logic          rfWriteEn;
    logic [AW-1:0] rfWriteAddr;
    logic [DW-1:0] rfWriteData;
    logic          privateWriteEn;
    logic [DW-1:0] privateWriteData;
    logic          fwdValid;
    logic [AW-1:0] fwdAddr;
    logic [DW-1:0] fwdData;
    logic [CW-1:0] retiredCount;

    writeback_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady),
        .regWrite(regWrite), .resultSel(resultSel), .dstOrPrivate(dstOrPrivate),
        .dstAddress(dstAddress), .aluData(aluData), .memData(memData),
        .inPortData(inPortData), .immData(immData), .dualWrite(dualWrite),
        .secondAddress(secondAddress), .secondData(secondData),
        .rfWriteEn(rfWriteEn), .rfWriteAddr(rfWriteAddr), .rfWriteData(rfWriteData),
        .privateWriteEn(privateWriteEn), .privateWriteData(privateWriteData),
        .fwdValid(fwdValid), .fwdAddr(fwdAddr), .fwdData(fwdData),
        .retiredCount(retiredCount)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;

    // Behavioural model: expected output values and the one-cycle stall after a dual write
    logic          mRfEn, mPvEn, mStall;
    logic [AW-1:0] mRfAddr, mSecAddr;
    logic [DW-1:0] mRfData, mPvData, mSecData;
    logic [CW-1:0] mCount;

    function automatic logic [DW-1:0] pickSource(input logic [1:0] s);
        case (s)
            2'd0:    return aluData;
            2'd1:    return memData;
            2'd2:    return inPortData;
            default: return immData;
        endcase
    endfunction

    task automatic setInstr(input logic v, input logic rw, input logic [1:0] sel, input logic priv,
                            input logic [AW-1:0] dst, input logic [DW-1:0] alu, input logic [DW-1:0] mem,
                            input logic [DW-1:0] inp, input logic [DW-1:0] imm, input logic dual,
                            input logic [AW-1:0] sa, input logic [DW-1:0] sd);
        inValid = v; regWrite = rw; resultSel = sel; dstOrPrivate = priv; dstAddress = dst;
        aluData = alu; memData = mem; inPortData = inp; immData = imm;
        dualWrite = dual; secondAddress = sa; secondData = sd;
    endtask

    // One clock: snapshot inputs, advance the model, leave the bench #1 after the edge
    task automatic tick();
        logic          cap, rw, priv, dual, r;
        logic [DW-1:0] v, sd;
        logic [AW-1:0] dst, sa;
        r = rst; cap = inValid && !rst && !mStall; v = pickSource(resultSel);
        rw = regWrite; priv = dstOrPrivate; dual = dualWrite; dst = dstAddress;
        sa = secondAddress; sd = secondData;
        @(posedge clk);
        #1;
        if (r) begin
            mRfEn = 1'b0; mPvEn = 1'b0; mStall = 1'b0; mRfAddr = '0; mRfData = '0;
            mPvData = '0; mCount = '0;
        end else if (cap) begin
            mRfEn = rw && !priv;
            mPvEn = rw && priv;
            if (mRfEn) begin mRfAddr = dst; mRfData = v; end
            if (mPvEn) mPvData = v;
            mCount = CW'((int'(mCount) + 1) % (1 << CW));
            mStall = rw && dual;
            if (mStall) begin mSecAddr = sa; mSecData = sd; end
        end else if (mStall) begin
            mRfEn = 1'b1; mRfAddr = mSecAddr; mRfData = mSecData; mPvEn = 1'b0; mStall = 1'b0;
        end else begin
            mRfEn = 1'b0; mPvEn = 1'b0;
        end
    endtask

    task automatic doReset();
        rst = 1'b1; inValid = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; setInstr(1'b1, 1'b1, 2'd0, 1'b0, 4'd1, 16'h1111, 16'h0, 16'h0, 16'h0, 1'b0, 4'd0, 16'h0);
        tick(); tick();
        nChecks++;
        if (inReady !== 1'b0) begin nFails++; $display("FAIL reset_inReady: got %b want 0", inReady); end
        nChecks++;
        if ({rfWriteEn, privateWriteEn, fwdValid, rfWriteAddr, rfWriteData, privateWriteData, retiredCount} !== '0) begin
            nFails++; $display("FAIL reset_outputs: rfEn=%b pvEn=%b addr=%h data=%h pv=%h cnt=%h want all 0",
                               rfWriteEn, privateWriteEn, rfWriteAddr, rfWriteData, privateWriteData, retiredCount);
        end
        rst = 1'b0; inValid = 1'b0;
        #1;
        nChecks++;
        if (inReady !== 1'b1) begin nFails++; $display("FAIL reset_release_ready: got %b want 1", inReady); end
    endtask

    task automatic test_alu_mem();
        doReset();
        setInstr(1'b1, 1'b1, 2'd0, 1'b0, 4'd3, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 1'b0, 4'd0, 16'h0);
        tick();
        setInstr(1'b1, 1'b1, 2'd1, 1'b0, 4'd5, 16'h0000, 16'hBEEF, 16'h0000, 16'h0000, 1'b0, 4'd0, 16'h0);
        nChecks++;
        if ({rfWriteEn, rfWriteAddr, rfWriteData} !== {1'b1, 4'd3, 16'h1234}) begin
            nFails++; $display("FAIL alu_write: got %b/%h/%h want 1/3/1234", rfWriteEn, rfWriteAddr, rfWriteData);
        end
        nChecks++;
        if ({fwdValid, fwdAddr, fwdData} !== {1'b1, 4'd3, 16'h1234}) begin
            nFails++; $display("FAIL alu_fwd: got %b/%h/%h want 1/3/1234", fwdValid, fwdAddr, fwdData);
        end
        tick();
        inValid = 1'b0;
        nChecks++;
        if ({rfWriteEn, rfWriteAddr, rfWriteData, fwdValid, fwdAddr, fwdData} !== {1'b1, 4'd5, 16'hBEEF, 1'b1, 4'd5, 16'hBEEF}) begin
            nFails++; $display("FAIL mem_write: got %b/%h/%h fwd %b/%h/%h want 1/5/BEEF",
                               rfWriteEn, rfWriteAddr, rfWriteData, fwdValid, fwdAddr, fwdData);
        end
        nChecks++;
        if (retiredCount !== 4'd2) begin nFails++; $display("FAIL alu_mem_count: got %0d want 2", retiredCount); end
        tick();
        nChecks++;
        if ({rfWriteEn, rfWriteAddr, rfWriteData} !== {1'b0, 4'd5, 16'hBEEF}) begin
            nFails++; $display("FAIL idle_hold: got %b/%h/%h want 0/5/BEEF", rfWriteEn, rfWriteAddr, rfWriteData);
        end
    endtask

    task automatic test_private();
        doReset();
        setInstr(1'b1, 1'b1, 2'd3, 1'b1, 4'd9, 16'h1111, 16'h2222, 16'h3333, 16'h00FF, 1'b0, 4'd0, 16'h0);
        tick();
        inValid = 1'b0;
        nChecks++;
        if ({privateWriteEn, privateWriteData} !== {1'b1, 16'h00FF}) begin
            nFails++; $display("FAIL private_write: got %b/%h want 1/00FF", privateWriteEn, privateWriteData);
        end
        nChecks++;
        if ({rfWriteEn, fwdValid} !== 2'b00) begin
            nFails++; $display("FAIL private_no_rf: got rfEn=%b fwd=%b want 0/0", rfWriteEn, fwdValid);
        end
        tick();
        nChecks++;
        if (privateWriteEn !== 1'b0) begin nFails++; $display("FAIL private_one_cycle: got %b want 0", privateWriteEn); end
    endtask

    task automatic test_dual();
        doReset();
        setInstr(1'b1, 1'b1, 2'd0, 1'b0, 4'd1, 16'hAAAA, 16'h0, 16'h0, 16'h0, 1'b1, 4'd2, 16'h5555);
        tick();
        setInstr(1'b1, 1'b1, 2'd2, 1'b0, 4'd7, 16'h0, 16'h0, 16'h7777, 16'h0, 1'b0, 4'd0, 16'h0);
        nChecks++;
        if ({rfWriteEn, rfWriteAddr, rfWriteData, inReady} !== {1'b1, 4'd1, 16'hAAAA, 1'b0}) begin
            nFails++; $display("FAIL dual_primary: got %b/%h/%h ready=%b want 1/1/AAAA ready=0",
                               rfWriteEn, rfWriteAddr, rfWriteData, inReady);
        end
        tick();
        nChecks++;
        if ({rfWriteEn, rfWriteAddr, rfWriteData, inReady} !== {1'b1, 4'd2, 16'h5555, 1'b1}) begin
            nFails++; $display("FAIL dual_second: got %b/%h/%h ready=%b want 1/2/5555 ready=1",
                               rfWriteEn, rfWriteAddr, rfWriteData, inReady);
        end
        tick();
        inValid = 1'b0;
        nChecks++;
        if ({rfWriteEn, rfWriteAddr, rfWriteData, fwdData} !== {1'b1, 4'd7, 16'h7777, 16'h7777}) begin
            nFails++; $display("FAIL dual_follow_on: got %b/%h/%h want 1/7/7777", rfWriteEn, rfWriteAddr, rfWriteData);
        end
        nChecks++;
        if (retiredCount !== 4'd2) begin nFails++; $display("FAIL dual_count: got %0d want 2", retiredCount); end
    endtask

    task automatic test_no_write();
        doReset();
        setInstr(1'b1, 1'b0, 2'd0, 1'b0, 4'd4, 16'h4444, 16'h0, 16'h0, 16'h0, 1'b1, 4'd6, 16'h6666);
        tick();
        inValid = 1'b0;
        nChecks++;
        if ({rfWriteEn, privateWriteEn, inReady, retiredCount} !== {1'b0, 1'b0, 1'b1, 4'd1}) begin
            nFails++; $display("FAIL no_write: got rfEn=%b pvEn=%b ready=%b cnt=%0d want 0/0/1/1",
                               rfWriteEn, privateWriteEn, inReady, retiredCount);
        end
        tick();
        nChecks++;
        if (rfWriteEn !== 1'b0) begin nFails++; $display("FAIL no_write_second: got rfEn=%b want 0", rfWriteEn); end
    endtask

    task automatic test_wrap();
        doReset();
        setInstr(1'b1, 1'b1, 2'd0, 1'b0, 4'd8, 16'h0808, 16'h0, 16'h0, 16'h0, 1'b0, 4'd0, 16'h0);
        for (int i = 0; i < 17; i++) tick();
        inValid = 1'b0;
        nChecks++;
        if (retiredCount !== 4'd1) begin nFails++; $display("FAIL count_wrap: got %0d want 1", retiredCount); end
    endtask

    task automatic test_reset_in_second();
        doReset();
        setInstr(1'b1, 1'b1, 2'd0, 1'b0, 4'd1, 16'hABCD, 16'h0, 16'h0, 16'h0, 1'b1, 4'd2, 16'hDCBA);
        tick();
        rst = 1'b1; inValid = 1'b0;
        tick();
        nChecks++;
        if ({inReady, rfWriteEn, privateWriteEn, rfWriteAddr, rfWriteData, retiredCount} !== '0) begin
            nFails++; $display("FAIL reset_second_outputs: ready=%b rfEn=%b pvEn=%b addr=%h data=%h cnt=%0d want all 0",
                               inReady, rfWriteEn, privateWriteEn, rfWriteAddr, rfWriteData, retiredCount);
        end
        rst = 1'b0;
        #1;
        nChecks++;
        if (inReady !== 1'b1) begin nFails++; $display("FAIL reset_second_ready: got %b want 1", inReady); end
        tick();
        nChecks++;
        if (rfWriteEn !== 1'b0) begin nFails++; $display("FAIL reset_second_dropped: got rfEn=%b want 0", rfWriteEn); end
    endtask

    task automatic test_random();
        logic [2+AW+DW+1+DW+1+AW+DW+CW-1:0] got, want;
        doReset();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            setInstr($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, 2'($urandom_range(0, 3)),
                     $urandom_range(0, 3) == 0, AW'($urandom), DW'($urandom), DW'($urandom),
                     DW'($urandom), DW'($urandom), $urandom_range(0, 2) == 0, AW'($urandom), DW'($urandom));
            tick();
            got  = {inReady, rfWriteEn, rfWriteAddr, rfWriteData, privateWriteEn, privateWriteData,
                    fwdValid, fwdAddr, fwdData, retiredCount};
            want = {!rst && !mStall, mRfEn, mRfAddr, mRfData, mPvEn, mPvData,
                    mRfEn, mRfAddr, mRfData, mCount};
            nChecks++;
            if (got !== want) begin
                nFails++; $display("FAIL random_cycle_%0d: got %h want %h", i, got, want);
            end
        end
    endtask

    initial begin
        mRfEn = 1'b0; mPvEn = 1'b0; mStall = 1'b0; mRfAddr = '0; mRfData = '0;
        mPvData = '0; mCount = '0; mSecAddr = '0; mSecData = '0;
        rst = 1'b1;
        setInstr(1'b0, 1'b0, 2'd0, 1'b0, 4'd0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 4'd0, 16'h0);
        test_reset();
        test_alu_mem();
        test_private();
        test_dual();
        test_no_write();
        test_wrap();
        test_reset_in_second();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Parametrised write-back stage for the pipelined RISC core.
- Captures retiring instructions from the memory stage and selects the result from one of four sources.
- Drives the register-file write port or the private-register write port, and mirrors each write onto a forwarding bus.
- Extends single-write behaviour with dual-register writes (SWAP-type) over two cycles, upstream stall, and a retired-instruction counter.

Parameters:
- DATA_WIDTH, 16, width of all data paths.
- REG_ADDR_WIDTH, 4, register-file address width.
- COUNT_WIDTH, 16, retired-instruction counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- inValid  in  1  memory stage presents an instruction.
- inReady  out  1  stage can accept; capture occurs when inValid && inReady.
- regWrite  in  1  instruction writes a register.
- resultSel  in  2  source select: ALU, memory, input port, immediate.
- dstOrPrivate  in  1  1 = primary write goes to the private register, 0 = register file.
- dstAddress  in  REG_ADDR_WIDTH  primary destination.
- aluData  in  DATA_WIDTH  ALU result.
- memData  in  DATA_WIDTH  memory read data.
- inPortData  in  DATA_WIDTH  input port value.
- immData  in  DATA_WIDTH  immediate value.
- dualWrite  in  1  instruction also writes a second register.
- secondAddress  in  REG_ADDR_WIDTH  second destination.
- secondData  in  DATA_WIDTH  second write value.
- rfWriteEn  out  1  register-file write strobe.
- rfWriteAddr  out  REG_ADDR_WIDTH  register-file write address.
- rfWriteData  out  DATA_WIDTH  register-file write data.
- privateWriteEn  out  1  private-register write strobe.
- privateWriteData  out  DATA_WIDTH  private-register data.
- fwdValid  out  1  forwarding bus valid; equals rfWriteEn.
- fwdAddr  out  REG_ADDR_WIDTH  forwarding address.
- fwdData  out  DATA_WIDTH  forwarding data.
- retiredCount  out  COUNT_WIDTH  accepted-instruction count.

Behaviour:
- Reset: clocked in while rst=1. All outputs and retiredCount go to 0 and the FSM enters IDLE; inReady=0 while rst=1.
- inReady = !rst && state!=SECOND. It is combinational from state and rst only, never from inValid.
- Latency: an instruction captured at edge N presents its primary write, registered, during cycle N+1.
- Strobes: every write strobe is high for exactly one cycle per write.
- Result mux encoding: 0 aluData, 1 memData, 2 inPortData, 3 immData.
- Primary write routing:
  - regWrite=1, dstOrPrivate=0: rfWriteEn=1, rfWriteAddr=dstAddress, rfWriteData=mux result.
  - regWrite=1, dstOrPrivate=1: privateWriteEn=1, privateWriteData=mux result; rfWriteEn=0.
  - regWrite=0: no strobe; the instruction still counts as retired.
- dualWrite is honoured only when regWrite=1; otherwise it is ignored and the instruction is single-cycle.
- FSM:
  - IDLE: accept → PRIMARY or SECOND. Capture with regWrite && dualWrite goes to SECOND; all other captures go to or stay in PRIMARY (the primary write is presented next cycle).
  - PRIMARY: same transitions as IDLE; no accept → IDLE.
  - SECOND: primary write is presented this cycle, inReady=0, and secondAddress/secondData are held internally. At the next edge the second write is presented (rfWriteEn=1, address=secondAddress, data=secondData, always to the register file) and the state moves to PRIMARY with inReady=1.
- Throughput: back-to-back single instructions run at one per cycle. A dual instruction costs exactly one stall cycle.
- Forwarding: fwdValid/fwdAddr/fwdData always equal rfWriteEn/rfWriteAddr/rfWriteData. Private writes are not forwarded.
- retiredCount increments by 1 on every capture and wraps modulo 2^COUNT_WIDTH. A dual write counts once.
- No capture: a cycle with inValid=0 and no pending second write deasserts all strobes. Data outputs hold their last values.
- Reset mid-operation: reset during SECOND discards the pending second write; no strobe is issued after reset.
- Input stability: inputs presented while inReady=0 are ignored; upstream holds them.

Decomposition:
- Package wb_pkg:
  - resultSel encodings SRC_ALU=2'd0, SRC_MEM=2'd1, SRC_INPORT=2'd2, SRC_IMM=2'd3.
  - FSM state encodings IDLE, PRIMARY, SECOND.
- Sub-module wb_result_mux: combinational 4:1 DATA_WIDTH-wide selector. The top level holds the capture registers, FSM, output registers and counter.

Test Plan:
- ALU vs memory: capture aluData=16'h1234, resultSel=0, dst=3, then memData=16'hBEEF, resultSel=1, dst=5 → next two cycles rfWriteEn=1 with (3,1234) then (5,BEEF); fwd bus identical; retiredCount=2.
- Private path: regWrite=1, dstOrPrivate=1, immData=16'h00FF, resultSel=3 → privateWriteEn=1, privateWriteData=00FF, rfWriteEn=0, fwdValid=0.
- Dual write: dst=1/aluData=16'hAAAA, dualWrite=1, secondAddress=2, secondData=16'h5555, with a follow-on instruction held valid → cycle+1: write (1,AAAA) and inReady=0; cycle+2: write (2,5555) and inReady=1; follow-on write in cycle+3; retiredCount=2.
- No write: regWrite=0, dualWrite=1 → no strobes, no stall, retiredCount+1.
- Wrap: COUNT_WIDTH=4, 17 single captures → retiredCount=1.
- Reset in SECOND: assert rst the cycle after a dual capture → no second write; all outputs 0 and inReady=0 during reset; inReady=1 the first cycle after release.
